axi_rd_slave_arbiter: RTL
=========================

// Module: axi_rd_slave_arbiter
// PURPOSE
// - Per-slave AXI read-channel arbiter in the crossbar; one instance per slave port.
// - Takes each master's ARVALID plus its decoded destination slave index from the address decoder.
// - Grants one requesting master at a time (round-robin) and holds the grant through the whole burst.
// - Drives the AR/R mux selects for its slave and releases the grant on the RLAST handshake.
// PARAMETERS
// - MASTERS   2    number of masters; legal range >= 2
// - SLAVES    2    number of slaves; sets DEST_W = $clog2(SLAVES)
// - SLAVE_ID  0    index of the slave this instance serves; 0..SLAVES-1
// - TIMEOUT   256  watchdog limit in cycles; used only when ARB_TIMEOUT_EN is defined
// PORTS
// - ACLK        in   1                clock; all logic is rising-edge
// - ARESETn     in   1                asynchronous active-low reset
// - m_arvalid   in   MASTERS          ARVALID of each master
// - m_ardest    in   MASTERS*DEST_W   decoded slave index per master; master i uses bits [i*DEST_W +: DEST_W]
// - s_arready   in   1                ARREADY from the slave
// - s_rvalid    in   1                RVALID from the slave
// - s_rready    in   1                RREADY from the granted master, already muxed
// - s_rlast     in   1                RLAST from the slave
// - grant       out  MASTERS          one-hot grant; all zero when no master is granted
// - grant_idx   out  $clog2(MASTERS)  binary index of the granted master
// - ar_en       out  1                enables the AR mux: master grant_idx drives the slave's AR channel
// - r_en        out  1                enables the R mux: slave R channel routes to master grant_idx
// - busy        out  1                asserted in any state other than IDLE
// - timeout_err out  1                one-cycle watchdog pulse; tied 0 without ARB_TIMEOUT_EN
// BEHAVIOUR
// - Reset values: all outputs 0; state = IDLE; round-robin pointer ptr = 0.
// - Request vector: req[i] = m_arvalid[i] && (m_ardest[i] == SLAVE_ID).
// - States and transitions:
//   - IDLE -> ADDR when |req.
//     - Winner = first i with req[i] set, scanning ptr, ptr+1, ... with wrap at MASTERS-1 -> 0.
//     - grant and grant_idx are registered, so they become valid the cycle after the request is seen.
//   - ADDR: ar_en = 1.
//     - Moves to DATA on the cycle s_arready = 1. AR handshake = ar_en & granted ARVALID & s_arready.
//     - R inputs are ignored in this state.
//   - DATA: r_en = 1, ar_en = 0.
//     - Moves to IDLE on the cycle s_rvalid & s_rready & s_rlast = 1.
//     - On that same edge, ptr <= (grant_idx == MASTERS-1) ? 0 : grant_idx + 1, and grant is cleared.
// - At most one outstanding read per slave. New requests are not sampled outside IDLE.
// - Latency:
//   - Request to ar_en: 1 cycle.
//   - RLAST handshake to next grant: 2 cycles (IDLE for 1 cycle, then grant).
// - A requester whose m_ardest differs from SLAVE_ID is never granted. Requests with dest >= SLAVES are never granted.
// - Fairness: a continuously requesting master is granted within MASTERS grants.
// - Reset asserted mid-burst:
//   - Immediately returns to IDLE and clears grant, ar_en and r_en.
//   - ptr goes to 0.
//   - Any partial burst is abandoned.
// - grant, grant_idx and busy are stable throughout ADDR and DATA, independent of m_arvalid changes.
// CONFIGURATION
// - Macro ARB_TIMEOUT_EN.
// - Defined:
//   - A counter clears on entry to ADDR and on every R beat handshake, and increments each cycle in ADDR or DATA.
//   - When it reaches TIMEOUT-1: timeout_err pulses for 1 cycle, state goes to IDLE, and ptr advances as on normal completion.
// - Undefined: no counter is built; timeout_err = 0; a stalled slave holds the grant indefinitely.
// TESTING
// - Reset: ARESETn = 0 with m_arvalid = 2'b11 -> grant = 0, ar_en = 0, busy = 0; after release, grant = 2'b01 one cycle later.
// - Contention, MASTERS = 2, SLAVE_ID = 0:
//   - Stimulus: m_arvalid = 11, both dests = 0; 4-beat bursts, RLAST on beat 4.
//   - Expected: grants alternate 01, 10, 01; next grant follows each RLAST handshake by 2 cycles.
// - Decode filter: m0 dest = 1, m1 dest = 0, both valid -> only grant = 2'b10; m0 is never granted.
// - Back-pressure:
//   - s_arready held 0 for 5 cycles -> ar_en stays 1 and state stays ADDR.
//   - s_rready = 0 while RLAST is valid -> no release until s_rready = 1.
// - Reset mid-burst: ARESETn = 0 during beat 2 of DATA -> r_en falls to 0 asynchronously; ptr = 0 after release.
// - ARB_TIMEOUT_EN with TIMEOUT = 16: AR accepted, then no RVALID -> timeout_err pulses once; busy = 0 the next cycle.

Source files
------------

// File: rtl/axi_rd_slave_arbiter.sv
// axi_rd_slave_arbiter
//   Per-slave AXI read-channel arbiter for the crossbar (one instance per
//   slave port). Picks one requesting master round-robin, holds the grant
//   through the AR handshake and the whole R burst, and releases it on the
//   RLAST handshake.
//
//   Optional feature: define ARB_TIMEOUT_EN to build a burst watchdog that
//   aborts a stalled transaction after TIMEOUT cycles without progress.
//
// Ports
//   ACLK, ARESETn   clock (rising edge) / asynchronous active-low reset
//   m_arvalid       ARVALID per master
//   m_ardest        decoded slave index per master, master i at [i*DEST_W +: DEST_W]
//   s_arready       ARREADY from the slave
//   s_rvalid/s_rready/s_rlast  R handshake (s_rready already muxed from the granted master)
//   grant           one-hot grant, zero when idle
//   grant_idx       binary index of the granted master
//   ar_en / r_en    AR / R mux enables
//   busy            arbiter is not IDLE
//   timeout_err     one-cycle watchdog pulse (0 without ARB_TIMEOUT_EN)
module axi_rd_slave_arbiter #(
   parameter  int MASTERS  = 2,
   parameter  int SLAVES   = 2,
   parameter  int SLAVE_ID = 0,
   parameter  int TIMEOUT  = 256,
   localparam int DEST_W   = (SLAVES > 1) ? $clog2(SLAVES) : 1,
   localparam int IDX_W    = $clog2(MASTERS)
) (
   input  logic                      ACLK,
   input  logic                      ARESETn,
   input  logic [MASTERS-1:0]        m_arvalid,
   input  logic [MASTERS*DEST_W-1:0] m_ardest,
   input  logic                      s_arready,
   input  logic                      s_rvalid,
   input  logic                      s_rready,
   input  logic                      s_rlast,
   output logic [MASTERS-1:0]        grant,
   output logic [IDX_W-1:0]          grant_idx,
   output logic                      ar_en,
   output logic                      r_en,
   output logic                      busy,
   output logic                      timeout_err
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

   state_e             state_q, state_d;
   logic [MASTERS-1:0] grant_q, grant_d, req;
   logic [IDX_W-1:0]   idx_q, idx_d, ptr_q, ptr_d, win_idx, cand, nxt_ptr;
   logic               ar_hs, r_beat, r_last_hs, tmo;

   // Destinations outside the slave range can never equal SLAVE_ID, so they
   // are filtered by the same compare.
   always_comb begin
      req = '0;
      for (int i = 0; i < MASTERS; i++)
         req[i] = m_arvalid[i] && (m_ardest[i*DEST_W +: DEST_W] == DEST_W'(SLAVE_ID));
   end

   // Round-robin pick: scan ptr, ptr+1, ... with wrap. Scanning from the far
   // end backwards lets the closest requester overwrite the result last.
   always_comb begin
      win_idx = ptr_q;
      cand    = '0;
      for (int k = MASTERS - 1; k >= 0; k--) begin
         cand = IDX_W'((int'(ptr_q) + k) % MASTERS);
         if (req[cand]) win_idx = cand;
      end
   end

   assign nxt_ptr   = (idx_q == IDX_W'(MASTERS - 1)) ? '0 : idx_q + 1'b1;
   assign ar_hs     = (state_q == ADDR) && m_arvalid[idx_q] && s_arready;
   assign r_beat    = (state_q == DATA) && s_rvalid && s_rready;
   assign r_last_hs = r_beat && s_rlast;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CNT_W-1:0] cnt_q;

   // Held at zero in IDLE, which gives the clear on entry to ADDR; any R beat
   // counts as progress and restarts the window.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn)                cnt_q <= '0;
      else if (state_q == IDLE)    cnt_q <= '0;
      else if (r_beat)             cnt_q <= '0;
      else                         cnt_q <= cnt_q + 1'b1;
   end

   assign tmo = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: if (|req) begin
            state_d = ADDR;
            idx_d   = win_idx;
            grant_d = MASTERS'(1) << win_idx;
         end
         ADDR: if (ar_hs) state_d = DATA;
         DATA: if (r_last_hs) begin
            state_d = IDLE;
            grant_d = '0;
            idx_d   = '0;
            ptr_d   = nxt_ptr;
         end
         default: state_d = IDLE;
      endcase
      // Watchdog abort behaves like a normal completion for fairness.
      if (tmo) begin
         state_d = IDLE;
         grant_d = '0;
         idx_d   = '0;
         ptr_d   = nxt_ptr;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
      end
   end

   // Enables decode straight from the state so reset drops them immediately.
   assign grant       = grant_q;
   assign grant_idx   = idx_q;
   assign ar_en       = (state_q == ADDR);
   assign r_en        = (state_q == DATA);
   assign busy        = (state_q != IDLE);
   assign timeout_err = tmo;

endmodule
